// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM pipeline stage.
//   state_t      data-memory handshake state encoding
//   TIMEOUT_DEF  default number of cycles a request may stay unacknowledged
//   REDIR_*      select values for the redirect-target mux
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int TIMEOUT_DEF = 15;

    localparam logic REDIR_BTARG = 1'b0;
    localparam logic REDIR_JTARG = 1'b1;

endpackage

// File: rtl/mem_handshake_fsm.sv
// mem_handshake_fsm: data-memory req/ack handshake controller with timeout.
//   Clk, Clr        clock (falling-edge active), synchronous active-high reset
//   memop, mem_wr   access wanted by the instruction in MEM, and whether it is a store
//   dm_ack          memory has completed the access
//   dm_req, dm_we   request and write strobe to the data memory
//   Stall           hold the upstream pipeline while the access is outstanding
//   timeout_hit     the outstanding access is being abandoned this cycle
//   BusErr          sticky flag, set on timeout, cleared only by Clr
module mem_handshake_fsm
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic Clk,
    input  logic Clr,
    input  logic memop,
    input  logic mem_wr,
    input  logic dm_ack,
    output logic dm_req,
    output logic dm_we,
    output logic Stall,
    output logic timeout_hit,
    output logic BusErr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             buserr_next;

    always_ff @(negedge Clk) begin
        if (Clr) begin
            state  <= IDLE;
            cnt    <= '0;
            BusErr <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            BusErr <= buserr_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        buserr_next = BusErr;
        dm_req      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                dm_req = memop;
                // An ack in the same cycle is a zero-wait access; stay in IDLE.
                if (memop && !dm_ack) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                dm_req      = 1'b1;
                timeout_hit = (cnt == CNT_LAST);
                if (dm_ack) begin
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next  = IDLE;
                    buserr_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dm_we = dm_req & mem_wr;
    // On the timeout cycle the pipeline is released even without an ack.
    assign Stall = dm_req & ~dm_ack & ~timeout_hit;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline (EX/MEM -> MEM/WB).
//   Clk, Clr           clock (falling-edge active), synchronous active-high reset
//   MEM_*              EX/MEM register outputs (address, store data, targets, controls)
//   dm_*               variable-latency data-memory req/ack interface
//   Stall              freeze PC, IF/ID, ID/EX, EX/MEM while an access is outstanding
//   Redirect/RedirectPC  taken branch or jump and its new PC
//   OvfExc             registered one-cycle overflow exception pulse
//   BusErr             sticky access-timeout flag
//   WB_*               MEM/WB register outputs feeding the write-back mux
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] MEM_ALUout,
    input  logic [31:0] MEM_busB,
    input  logic [31:0] MEM_Btarg,
    input  logic [31:0] MEM_Jtarg,
    input  logic [4:0]  MEM_Rw,
    input  logic        MEM_Zero,
    input  logic        MEM_Overflow,
    input  logic        MEM_RegWr,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemWr,
    input  logic        MEM_Branch,
    input  logic        MEM_Jump,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        Stall,
    output logic        Redirect,
    output logic [31:0] RedirectPC,
    output logic        OvfExc,
    output logic        BusErr,
    output logic        WB_RegWr,
    output logic        WB_MemtoReg,
    output logic [4:0]  WB_Rw,
    output logic [31:0] WB_ALUout,
    output logic [31:0] WB_MemData
);

    logic memop;
    logic timeout_hit;
    logic redir_sel;
    logic regwr_next;
    logic rdata_cap;

    // An overflowed instruction never touches memory.
    assign memop = (MEM_MemtoReg | MEM_MemWr) & ~MEM_Overflow;

    mem_handshake_fsm #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_fsm (
        .Clk         (Clk),
        .Clr         (Clr),
        .memop       (memop),
        .mem_wr      (MEM_MemWr),
        .dm_ack      (dm_ack),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .Stall       (Stall),
        .timeout_hit (timeout_hit),
        .BusErr      (BusErr)
    );

    assign dm_addr  = MEM_ALUout;
    assign dm_wdata = MEM_busB;

    // Jump wins over branch when both are flagged.
    assign Redirect   = (MEM_Branch & MEM_Zero) | MEM_Jump;
    assign redir_sel  = MEM_Jump ? REDIR_JTARG : REDIR_BTARG;
    assign RedirectPC = (redir_sel == REDIR_JTARG) ? MEM_Jtarg : MEM_Btarg;

    // A timed-out load must not write back stale data.
    assign regwr_next = MEM_RegWr & ~MEM_Overflow & ~timeout_hit;
    // Load data is only meaningful while our own read request is acknowledged.
    assign rdata_cap  = dm_req & dm_ack & ~dm_we;

    // MEM/WB boundary
    always_ff @(negedge Clk) begin
        if (Clr) begin
            WB_RegWr    <= 1'b0;
            WB_MemtoReg <= 1'b0;
            WB_Rw       <= '0;
            WB_ALUout   <= '0;
            WB_MemData  <= '0;
            OvfExc      <= 1'b0;
        end else if (Stall) begin
            WB_RegWr    <= 1'b0;
            WB_MemtoReg <= 1'b0;
            OvfExc      <= 1'b0;
        end else begin
            WB_RegWr    <= regwr_next;
            WB_MemtoReg <= MEM_MemtoReg & regwr_next;
            WB_Rw       <= MEM_Rw;
            WB_ALUout   <= MEM_ALUout;
            OvfExc      <= MEM_Overflow & MEM_RegWr;
            if (rdata_cap) begin
                WB_MemData <= dm_rdata;
            end
        end
    end

endmodule
